// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: FSM encodings, score format
// and the packed-BCD increment used by the score counter.
package game_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_PLAY   = 3'd1;
    localparam state_t ST_PAUSED = 3'd2;
    localparam state_t ST_DYING  = 3'd3;
    localparam state_t ST_OVER   = 3'd4;

    localparam int BCD_DIGITS = 4;
    localparam int SCORE_W    = 16;

    localparam logic [SCORE_W-1:0] BCD_MAX = 16'h9999;

    // Add one to a packed BCD value with per-digit carry. Any digit at 9
    // (or an out-of-range A-F nibble) rolls to 0 and carries onward.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_ctrl_bcd_counter.sv
// Four-digit packed BCD counter that saturates at 9999; clear beats inc.
module bcd_counter
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] q
);

    logic [SCORE_W-1:0] cnt_q;
    logic [SCORE_W-1:0] cnt_d;

    // Next count: clear first, then a saturating BCD increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != BCD_MAX)) begin
            cnt_d = bcd_inc(cnt_q);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: play/pause/death/over FSM, button edge detection, flap
// cooldown, per-frame physics gating, score and high score tracking.
module game_ctrl
    import game_pkg::*;
#(
    parameter int DEATH_FRAMES  = 60,
    parameter int FLAP_COOLDOWN = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               frame_tick,
    input  logic               pause,
    input  logic               flap,
    input  logic               collide,
    input  logic               pipe_passed,
    output logic [STATE_W-1:0] state,
    output logic               phys_en,
    output logic               flap_req,
    output logic               world_rst,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score
);

    localparam logic [7:0] DEATH_INIT = 8'(DEATH_FRAMES);
    localparam logic [3:0] CD_INIT    = 4'(FLAP_COOLDOWN);

    logic               flap_q;
    logic               pause_q;
    logic               flap_e;
    logic               pause_e;

    state_t             state_q,     state_d;
    logic               phys_en_q,   phys_en_d;
    logic               flap_req_q,  flap_req_d;
    logic               world_rst_q, world_rst_d;
    logic [3:0]         cd_q,        cd_d;
    logic [7:0]         dc_q,        dc_d;
    logic [SCORE_W-1:0] hi_q,        hi_d;

    logic               score_clear;
    logic               score_inc;
    logic [SCORE_W-1:0] score_cur;

    // Rising edges are used in the same cycle they are seen; history resets
    // high so a button held through reset does not count as a press.
    assign flap_e  = flap  & ~flap_q;
    assign pause_e = pause & ~pause_q;

    // FSM next-state and the one-cycle control pulses it produces.
    always_comb begin
        state_d     = state_q;
        phys_en_d   = 1'b0;
        flap_req_d  = 1'b0;
        world_rst_d = 1'b0;
        cd_d        = cd_q;
        dc_d        = dc_q;
        hi_d        = hi_q;
        score_clear = 1'b0;
        score_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (flap_e) begin
                    world_rst_d = 1'b1;
                    flap_req_d  = 1'b1;
                    score_clear = 1'b1;
                    cd_d        = CD_INIT;
                    state_d     = ST_PLAY;
                end
            end

            ST_PLAY: begin
                phys_en_d = frame_tick;
                if (frame_tick && (cd_q != 4'd0)) begin
                    cd_d = cd_q - 4'd1;
                end
                if (collide) begin
                    // A hit swallows any same-cycle pipe credit or flap.
                    state_d = ST_DYING;
                    dc_d    = DEATH_INIT;
                end else begin
                    score_inc = pipe_passed;
                    if (pause_e) begin
                        state_d = ST_PAUSED;
                    end else if (flap_e && (cd_q == 4'd0)) begin
                        flap_req_d = 1'b1;
                        cd_d       = CD_INIT;
                    end
                end
            end

            ST_PAUSED: begin
                if (pause_e) begin
                    state_d = ST_PLAY;
                end
            end

            ST_DYING: begin
                phys_en_d = frame_tick;
                if (frame_tick) begin
                    // A zero counter here cannot occur normally; leaving on it
                    // keeps the FSM from stalling in DYING.
                    if (dc_q <= 8'd1) begin
                        dc_d    = 8'd0;
                        state_d = ST_OVER;
                        if (score_cur > hi_q) begin
                            hi_d = score_cur;
                        end
                    end else begin
                        dc_d = dc_q - 8'd1;
                    end
                end
            end

            ST_OVER: begin
                if (flap_e) begin
                    world_rst_d = 1'b1;
                    score_clear = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            flap_q      <= 1'b1;
            pause_q     <= 1'b1;
            state_q     <= ST_IDLE;
            phys_en_q   <= 1'b0;
            flap_req_q  <= 1'b0;
            world_rst_q <= 1'b0;
            cd_q        <= 4'd0;
            dc_q        <= 8'd0;
            hi_q        <= '0;
        end else begin
            flap_q      <= flap;
            pause_q     <= pause;
            state_q     <= state_d;
            phys_en_q   <= phys_en_d;
            flap_req_q  <= flap_req_d;
            world_rst_q <= world_rst_d;
            cd_q        <= cd_d;
            dc_q        <= dc_d;
            hi_q        <= hi_d;
        end
    end

    bcd_counter u_score (
        .clk   (clk),
        .clr   (clr),
        .clear (score_clear),
        .inc   (score_inc),
        .q     (score_cur)
    );

    assign state     = state_q;
    assign phys_en   = phys_en_q;
    assign flap_req  = flap_req_q;
    assign world_rst = world_rst_q;
    assign score     = score_cur;
    assign hi_score  = hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: reset, start, flap cooldown, pause,
// death sequence, high score and BCD score boundaries.
`timescale 1ns/1ps
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        frame_tick = 1'b0;
    logic        pause = 1'b0;
    logic        flap = 1'b0;
    logic        collide = 1'b0;
    logic        pipe_passed = 1'b0;
    logic [2:0]  state;
    logic        phys_en;
    logic        flap_req;
    logic        world_rst;
    logic [15:0] score;
    logic [15:0] hi_score;

    int checks = 0;
    int failures = 0;

    game_ctrl #(.DEATH_FRAMES(60), .FLAP_COOLDOWN(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .frame_tick  (frame_tick),
        .pause       (pause),
        .flap        (flap),
        .collide     (collide),
        .pipe_passed (pipe_passed),
        .state       (state),
        .phys_en     (phys_en),
        .flap_req    (flap_req),
        .world_rst   (world_rst),
        .score       (score),
        .hi_score    (hi_score)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(output logic pe);
        frame_tick = 1'b1;
        tick();
        pe = phys_en;
        frame_tick = 1'b0;
        tick();
    endtask

    task automatic do_flap(output logic fr, output logic wr);
        flap = 1'b1;
        tick();
        fr = flap_req;
        wr = world_rst;
        flap = 1'b0;
        tick();
    endtask

    task automatic do_pause();
        pause = 1'b1;
        tick();
        pause = 1'b0;
        tick();
    endtask

    task automatic pipe_pulse();
        pipe_passed = 1'b1;
        tick();
        pipe_passed = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        flap = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        tick();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (score !== 16'h0000) begin failures++; $display("FAIL reset_score got=%h exp=0000", score); end
        checks++; if (hi_score !== 16'h0000) begin failures++; $display("FAIL reset_hi got=%h exp=0000", hi_score); end
        checks++; if (flap_req !== 1'b0) begin failures++; $display("FAIL reset_flap_req got=%b exp=0", flap_req); end
        checks++; if (world_rst !== 1'b0) begin failures++; $display("FAIL reset_world_rst got=%b exp=0", world_rst); end
        checks++; if (phys_en !== 1'b0) begin failures++; $display("FAIL reset_phys_en got=%b exp=0", phys_en); end
    endtask

    task automatic test_start();
        flap = 1'b0;
        tick();
        flap = 1'b1;
        tick();
        checks++; if (world_rst !== 1'b1) begin failures++; $display("FAIL start_world_rst got=%b exp=1", world_rst); end
        checks++; if (flap_req !== 1'b1) begin failures++; $display("FAIL start_flap_req got=%b exp=1", flap_req); end
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", state); end
        flap = 1'b0;
        tick();
        checks++; if (world_rst !== 1'b0) begin failures++; $display("FAIL start_world_rst_pulse got=%b exp=0", world_rst); end
        checks++; if (flap_req !== 1'b0) begin failures++; $display("FAIL start_flap_req_pulse got=%b exp=0", flap_req); end
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_state_hold got=%0d exp=1", state); end
    endtask

    task automatic test_cooldown();
        logic pe, fr, wr;
        // Let the cooldown armed by the start flap run out.
        frame(pe);
        checks++; if (pe !== 1'b1) begin failures++; $display("FAIL play_phys_en got=%b exp=1", pe); end
        repeat (3) frame(pe);
        frame(pe);                  // frame 0
        do_flap(fr, wr);
        checks++; if (fr !== 1'b1) begin failures++; $display("FAIL cd_frame0 got=%b exp=1", fr); end
        frame(pe);                  // frame 1
        frame(pe);                  // frame 2
        do_flap(fr, wr);
        checks++; if (fr !== 1'b0) begin failures++; $display("FAIL cd_frame2 got=%b exp=0", fr); end
        frame(pe);                  // frame 3
        frame(pe);                  // frame 4
        frame(pe);                  // frame 5
        do_flap(fr, wr);
        checks++; if (fr !== 1'b1) begin failures++; $display("FAIL cd_frame5 got=%b exp=1", fr); end
    endtask

    task automatic test_pause();
        logic pe, fr, wr, any_pe;
        pause = 1'b1;
        pipe_passed = 1'b1;
        tick();
        pause = 1'b0;
        pipe_passed = 1'b0;
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL pause_state got=%0d exp=2", state); end
        checks++; if (score !== 16'h0001) begin failures++; $display("FAIL pause_pipe_scores got=%h exp=0001", score); end
        tick();
        any_pe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            frame(pe);
            any_pe = any_pe | pe;
        end
        checks++; if (any_pe !== 1'b0) begin failures++; $display("FAIL paused_phys_en got=%b exp=0", any_pe); end
        do_flap(fr, wr);
        checks++; if (fr !== 1'b0) begin failures++; $display("FAIL paused_flap got=%b exp=0", fr); end
        pipe_pulse();
        checks++; if (score !== 16'h0001) begin failures++; $display("FAIL paused_pipe got=%h exp=0001", score); end
        collide = 1'b1;
        tick();
        collide = 1'b0;
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL paused_collide got=%0d exp=2", state); end
        do_pause();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL resume_state got=%0d exp=1", state); end
        frame(pe);
        checks++; if (pe !== 1'b1) begin failures++; $display("FAIL resume_phys_en got=%b exp=1", pe); end
    endtask

    task automatic test_death();
        logic pe;
        repeat (6) pipe_pulse();
        checks++; if (score !== 16'h0007) begin failures++; $display("FAIL score_seven got=%h exp=0007", score); end
        collide = 1'b1;
        pipe_passed = 1'b1;
        tick();
        collide = 1'b0;
        pipe_passed = 1'b0;
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL dying_state got=%0d exp=3", state); end
        checks++; if (score !== 16'h0007) begin failures++; $display("FAIL dying_score got=%h exp=0007", score); end
        frame(pe);
        checks++; if (pe !== 1'b1) begin failures++; $display("FAIL dying_phys_en got=%b exp=1", pe); end
        repeat (58) frame(pe);
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL dying_59 got=%0d exp=3", state); end
        frame(pe);
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL over_state got=%0d exp=4", state); end
        checks++; if (hi_score !== 16'h0007) begin failures++; $display("FAIL over_hi got=%h exp=0007", hi_score); end
        frame(pe);
        checks++; if (pe !== 1'b0) begin failures++; $display("FAIL over_phys_en got=%b exp=0", pe); end
    endtask

    task automatic test_over_restart();
        logic fr, wr;
        do_flap(fr, wr);
        checks++; if (wr !== 1'b1) begin failures++; $display("FAIL over_world_rst got=%b exp=1", wr); end
        checks++; if (fr !== 1'b0) begin failures++; $display("FAIL over_flap_req got=%b exp=0", fr); end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL over_to_idle got=%0d exp=0", state); end
        checks++; if (score !== 16'h0000) begin failures++; $display("FAIL over_score_clr got=%h exp=0000", score); end
    endtask

    task automatic test_second_game();
        logic pe, fr, wr;
        do_flap(fr, wr);
        checks++; if (fr !== 1'b1) begin failures++; $display("FAIL game2_start got=%b exp=1", fr); end
        repeat (3) pipe_pulse();
        collide = 1'b1;
        tick();
        collide = 1'b0;
        repeat (60) frame(pe);
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL game2_over got=%0d exp=4", state); end
        checks++; if (score !== 16'h0003) begin failures++; $display("FAIL game2_score got=%h exp=0003", score); end
        checks++; if (hi_score !== 16'h0007) begin failures++; $display("FAIL game2_hi got=%h exp=0007", hi_score); end
        do_flap(fr, wr);
    endtask

    task automatic test_score_bcd();
        logic pe, fr, wr;
        do_flap(fr, wr);
        repeat (12) pipe_pulse();
        checks++; if (score !== 16'h0012) begin failures++; $display("FAIL score_12 got=%h exp=0012", score); end
        repeat (87) pipe_pulse();
        checks++; if (score !== 16'h0099) begin failures++; $display("FAIL score_99 got=%h exp=0099", score); end
        pipe_pulse();
        checks++; if (score !== 16'h0100) begin failures++; $display("FAIL score_carry got=%h exp=0100", score); end
        pipe_passed = 1'b1;
        repeat (9899) tick();
        pipe_passed = 1'b0;
        checks++; if (score !== 16'h9999) begin failures++; $display("FAIL score_9999 got=%h exp=9999", score); end
        pipe_pulse();
        checks++; if (score !== 16'h9999) begin failures++; $display("FAIL score_sat got=%h exp=9999", score); end
        collide = 1'b1;
        tick();
        collide = 1'b0;
        repeat (60) frame(pe);
        checks++; if (hi_score !== 16'h9999) begin failures++; $display("FAIL hi_9999 got=%h exp=9999", hi_score); end
    endtask

    task automatic test_clr_mid_game();
        logic fr, wr;
        do_flap(fr, wr);            // OVER -> IDLE
        do_flap(fr, wr);            // IDLE -> PLAY
        pipe_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL clr_state got=%0d exp=0", state); end
        checks++; if (score !== 16'h0000) begin failures++; $display("FAIL clr_score got=%h exp=0000", score); end
        checks++; if (hi_score !== 16'h0000) begin failures++; $display("FAIL clr_hi got=%h exp=0000", hi_score); end
        checks++; if (world_rst !== 1'b0) begin failures++; $display("FAIL clr_world_rst got=%b exp=0", world_rst); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_cooldown();
        test_pause();
        test_death();
        test_over_restart();
        test_second_game();
        test_score_bcd();
        test_clr_mid_game();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
